// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - UART byte-stream command decoder driving a register bus and tx responses
// Optional build macro UART_CMD_ECHO_EN echoes non-header bytes received while idle.
module uart_cmd_parser #(
  parameter logic [7:0] HDR_BYTE    = 8'h55,
  parameter logic [7:0] ACK_BYTE    = 8'hAA,
  parameter logic [7:0] NAK_BYTE    = 8'hEE,
  parameter int         TIMEOUT_CYC = 25920
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_en,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       frame_err
);
  localparam int               TMR_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]       CMD_WR   = 8'h01;
  localparam logic [7:0]       CMD_RD   = 8'h02;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [2:0] S_EXEC  = 3'd5;
  localparam logic [2:0] S_RDLAT = 3'd6;
  localparam logic [2:0] S_RESP  = 3'd7;

  logic [2:0]       r_state;
  logic [7:0]       r_cmd;
  logic [TMR_W-1:0] r_timer;
  logic [7:0]       r_resp0;
  logic [7:0]       r_resp1;
  logic [1:0]       r_rcnt;
  logic [1:0]       r_guard;
  logic [7:0]       r_tx_data;
  logic             r_tx_en;
  logic [7:0]       r_reg_addr;
  logic [7:0]       r_reg_wdata;
  logic             r_reg_we;
  logic             r_reg_re;
  logic             r_frame_err;

  logic w_tx_ready;
  logic w_resp_go;
  logic w_csum_ok;

  // Guard counter masks tx_busy for two cycles after each tx_en (transmitter latch latency).
  assign w_tx_ready = (r_guard == 2'd0) && !tx_busy;
  assign w_csum_ok  = (rx_data == ((r_cmd == CMD_WR) ? (r_cmd ^ r_reg_addr ^ r_reg_wdata)
                                                      : (r_cmd ^ r_reg_addr)));

`ifdef UART_CMD_ECHO_EN
  logic       r_echo_pend;
  logic [7:0] r_echo_byte;
  // A pending echo owns the transmitter before any frame response.
  assign w_resp_go = w_tx_ready && !r_echo_pend;
`else
  assign w_resp_go = w_tx_ready;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cmd       <= '0;
      r_timer     <= '0;
      r_resp0     <= '0;
      r_resp1     <= '0;
      r_rcnt      <= '0;
      r_guard     <= '0;
      r_tx_data   <= '0;
      r_tx_en     <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_reg_we    <= 1'b0;
      r_reg_re    <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_CMD_ECHO_EN
      r_echo_pend <= 1'b0;
      r_echo_byte <= '0;
`endif
    end else begin
      r_tx_en     <= 1'b0;
      r_reg_we    <= 1'b0;
      r_reg_re    <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_guard != 2'd0) r_guard <= r_guard - 2'd1;
`ifdef UART_CMD_ECHO_EN
      if (r_echo_pend && w_tx_ready) begin
        r_tx_en     <= 1'b1;
        r_tx_data   <= r_echo_byte;
        r_guard     <= 2'd2;
        r_echo_pend <= 1'b0;
      end
`endif
      case (r_state)
        S_IDLE: begin
          if (rx_en) begin
            if (rx_data == HDR_BYTE) begin
              r_state <= S_CMD;
              r_timer <= '0;
            end
`ifdef UART_CMD_ECHO_EN
            else if (!r_echo_pend) begin
              r_echo_pend <= 1'b1;
              r_echo_byte <= rx_data;
            end
`endif
          end
        end
        S_CMD, S_ADDR, S_DATA, S_CSUM: begin
          if (rx_en) begin
            r_timer <= '0;
            case (r_state)
              S_CMD: begin
                r_cmd <= rx_data;
                if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                  r_state <= S_ADDR;
                end else begin
                  r_frame_err <= 1'b1;
                  r_resp0     <= NAK_BYTE;
                  r_rcnt      <= 2'd1;
                  r_state     <= S_RESP;
                end
              end
              S_ADDR: begin
                r_reg_addr <= rx_data;
                r_state    <= (r_cmd == CMD_WR) ? S_DATA : S_CSUM;
              end
              S_DATA: begin
                r_reg_wdata <= rx_data;
                r_state     <= S_CSUM;
              end
              default: begin
                if (w_csum_ok) begin
                  // Strobes are registered here so they are high during S_EXEC.
                  r_reg_we <= (r_cmd == CMD_WR);
                  r_reg_re <= (r_cmd != CMD_WR);
                  r_state  <= S_EXEC;
                end else begin
                  r_frame_err <= 1'b1;
                  r_resp0     <= NAK_BYTE;
                  r_rcnt      <= 2'd1;
                  r_state     <= S_RESP;
                end
              end
            endcase
          end else if (r_timer == TMR_LAST) begin
            r_frame_err <= 1'b1;
            r_timer     <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_EXEC: begin
          if (r_cmd == CMD_WR) begin
            r_resp0 <= ACK_BYTE;
            r_rcnt  <= 2'd1;
            r_state <= S_RESP;
          end else begin
            r_state <= S_RDLAT;
          end
        end
        S_RDLAT: begin
          r_resp0 <= ACK_BYTE;
          r_resp1 <= reg_rdata;
          r_rcnt  <= 2'd2;
          r_state <= S_RESP;
        end
        default: begin
          if (w_resp_go) begin
            r_tx_en   <= 1'b1;
            r_tx_data <= r_resp0;
            r_resp0   <= r_resp1;
            r_rcnt    <= r_rcnt - 2'd1;
            r_guard   <= 2'd2;
            if (r_rcnt <= 2'd1) r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign tx_data   = r_tx_data;
  assign tx_en     = r_tx_en;
  assign reg_addr  = r_reg_addr;
  assign reg_wdata = r_reg_wdata;
  assign reg_we    = r_reg_we;
  assign reg_re    = r_reg_re;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - self-checking bench for uart_cmd_parser (table, hand sequences, random frames)
module tb_uart_cmd_parser;
  localparam int TO = 200;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_en;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_en;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       frame_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] pmem [256];
  logic [7:0] exp_mem [256];
  logic [7:0] tx_q [$];
  logic [7:0] we_a_q [$];
  logic [7:0] we_d_q [$];
  int re_cnt, err_cnt, viol_cnt, busy_cnt, busy_fixed, busy_max;
  int we_cyc, re_cyc, last_rx_cyc;
  bit rd_arm, rd_valid;
  logic [7:0] rd_addr;

  typedef struct {
    logic [7:0] b [5];
    int n;
    int ntx;
    logic [7:0] tx0;
    logic [7:0] tx1;
    int we;
    logic [7:0] wa;
    logic [7:0] wd;
    int re;
    int err;
  } vec_t;
  vec_t vecs [6];

  uart_cmd_parser #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_en(rx_en), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_en(tx_en), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter and register-file models plus event recorder, evaluated mid-cycle.
  always @(negedge clk) begin
    if (rd_valid) begin
      reg_rdata = 8'($urandom);
      rd_valid  = 1'b0;
    end
    if (rd_arm) begin
      reg_rdata = pmem[rd_addr];
      rd_arm    = 1'b0;
      rd_valid  = 1'b1;
    end
    if (reg_re) begin
      rd_arm  = 1'b1;
      rd_addr = reg_addr;
      re_cnt++;
      re_cyc = cyc;
    end
    if (reg_we) begin
      pmem[reg_addr] = reg_wdata;
      we_a_q.push_back(reg_addr);
      we_d_q.push_back(reg_wdata);
      we_cyc = cyc;
    end
    if (frame_err) err_cnt++;
    if (tx_en) begin
      if (tx_busy) viol_cnt++;
      tx_q.push_back(tx_data);
      busy_cnt = (busy_fixed >= 0) ? busy_fixed : $urandom_range(0, busy_max);
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy = (busy_cnt != 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_rec();
    tx_q.delete();
    we_a_q.delete();
    we_d_q.delete();
    re_cnt  = 0;
    err_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data     = b;
    rx_en       = 1'b1;
    last_rx_cyc = cyc;
    tick();
    rx_en = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] fr [$], input int gmax);
    foreach (fr[i]) begin
      send_byte(fr[i]);
      repeat ($urandom_range(0, gmax)) tick();
    end
  endtask

  task automatic wait_resp(input int n);
    int k = 0;
    while (tx_q.size() < n && k < 3000) begin
      tick();
      k++;
    end
    repeat (60) tick();
  endtask

  // Reference: decode a frame from its byte rules and update the expected register image.
  task automatic model_frame(input logic [7:0] fr [$], output logic [7:0] etx [$],
                             output int ewe, output logic [7:0] ewa, output logic [7:0] ewd,
                             output int ere, output int eerr);
    logic [7:0] cmd, addr, data, cs, sum;
    etx = {};
    ewe = 0; ere = 0; eerr = 0; ewa = 0; ewd = 0;
    cmd = fr[1];
    if (cmd != 8'h01 && cmd != 8'h02) begin
      eerr = 1;
      etx.push_back(8'hEE);
      return;
    end
    addr = fr[2];
    data = 8'h00;
    if (cmd == 8'h01) begin
      data = fr[3];
      cs   = fr[4];
      sum  = cmd ^ addr ^ data;
    end else begin
      cs  = fr[3];
      sum = cmd ^ addr;
    end
    if (cs != sum) begin
      eerr = 1;
      etx.push_back(8'hEE);
    end else if (cmd == 8'h01) begin
      exp_mem[addr] = data;
      ewe = 1; ewa = addr; ewd = data;
      etx.push_back(8'hAA);
    end else begin
      ere = 1;
      etx.push_back(8'hAA);
      etx.push_back(exp_mem[addr]);
    end
  endtask

  task automatic check_frame(input string name, input logic [7:0] etx [$], input int ewe,
                             input logic [7:0] ewa, input logic [7:0] ewd, input int ere,
                             input int eerr);
    chk({name, " ntx"}, tx_q.size(), etx.size());
    foreach (etx[i])
      if (i < tx_q.size()) chk($sformatf("%s tx[%0d]", name, i), tx_q[i], etx[i]);
    chk({name, " we_cnt"}, we_a_q.size(), ewe);
    if (ewe == 1 && we_a_q.size() > 0) begin
      chk({name, " we_addr"}, we_a_q[0], ewa);
      chk({name, " we_data"}, we_d_q[0], ewd);
      chk({name, " we_lat"}, we_cyc - last_rx_cyc, 1);
    end
    chk({name, " re_cnt"}, re_cnt, ere);
    if (ere == 1 && re_cnt > 0) chk({name, " re_lat"}, re_cyc - last_rx_cyc, 1);
    chk({name, " err_cnt"}, err_cnt, eerr);
  endtask

  task automatic run_model_frame(input string name, input logic [7:0] fr [$], input int gmax);
    logic [7:0] etx [$];
    int ewe, ere, eerr;
    logic [7:0] ewa, ewd;
    model_frame(fr, etx, ewe, ewa, ewd, ere, eerr);
    clear_rec();
    send_frame(fr, gmax);
    wait_resp(etx.size());
    check_frame(name, etx, ewe, ewa, ewd, ere, eerr);
  endtask

  function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, b4, input int n, input int ntx,
                              input logic [7:0] tx0, tx1, input int we, input logic [7:0] wa,
                              input logic [7:0] wd, input int re, input int err);
    vec_t v;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
    v.n = n; v.ntx = ntx; v.tx0 = tx0; v.tx1 = tx1;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.err = err;
    return v;
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fr [$];
    logic [7:0] etx [$];
    logic [7:0] v, g, c, a, d, cs;
    int kind;
    bit garb;

    vecs[0] = mk(8'h55, 8'h01, 8'h10, 8'h3C, 8'h2D, 5, 1, 8'hAA, 8'h00, 1, 8'h10, 8'h3C, 0, 0);
    vecs[1] = mk(8'h55, 8'h02, 8'h20, 8'h22, 8'h00, 4, 2, 8'hAA, 8'h5A, 0, 8'h00, 8'h00, 1, 0);
    vecs[2] = mk(8'h55, 8'h01, 8'h10, 8'h3C, 8'h00, 5, 1, 8'hEE, 8'h00, 0, 8'h00, 8'h00, 0, 1);
    vecs[3] = mk(8'h55, 8'h07, 8'h00, 8'h00, 8'h00, 2, 1, 8'hEE, 8'h00, 0, 8'h00, 8'h00, 0, 1);
    vecs[4] = mk(8'h55, 8'h01, 8'h10, 8'h3C, 8'h2D, 5, 1, 8'hAA, 8'h00, 1, 8'h10, 8'h3C, 0, 0);
    vecs[5] = mk(8'h55, 8'h02, 8'h10, 8'h12, 8'h00, 4, 2, 8'hAA, 8'h3C, 0, 8'h00, 8'h00, 1, 0);

    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      pmem[i] = v;
      exp_mem[i] = v;
    end
    pmem[8'h20] = 8'h5A;
    exp_mem[8'h20] = 8'h5A;
    rst = 1'b1; rx_en = 1'b0; rx_data = 8'h00; tx_busy = 1'b0; reg_rdata = 8'h00;
    rd_arm = 1'b0; rd_valid = 1'b0; rd_addr = 8'h00;
    busy_cnt = 0; busy_fixed = -1; busy_max = 6; viol_cnt = 0;
    we_cyc = 0; re_cyc = 0; last_rx_cyc = 0;
    clear_rec();
    repeat (3) tick();
    chk("reset strobes", {tx_en, reg_we, reg_re, frame_err}, 4'b0000);
    chk("reset tx_data", tx_data, 8'h00);
    chk("reset reg_addr", reg_addr, 8'h00);
    chk("reset reg_wdata", reg_wdata, 8'h00);
    rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 6; i++) begin
      fr = {};
      for (int j = 0; j < vecs[i].n; j++) fr.push_back(vecs[i].b[j]);
      etx = {};
      if (vecs[i].ntx > 0) etx.push_back(vecs[i].tx0);
      if (vecs[i].ntx > 1) etx.push_back(vecs[i].tx1);
      if (vecs[i].we == 1) exp_mem[vecs[i].wa] = vecs[i].wd;
      clear_rec();
      send_frame(fr, 3);
      wait_resp(vecs[i].ntx);
      check_frame($sformatf("vec%0d", i), etx, vecs[i].we, vecs[i].wa, vecs[i].wd,
                  vecs[i].re, vecs[i].err);
    end

`ifdef UART_CMD_ECHO_EN
    clear_rec();
    send_byte(8'h41);
    wait_resp(1);
    chk("echo ntx", tx_q.size(), 1);
    if (tx_q.size() > 0) chk("echo byte", tx_q[0], 8'h41);
    chk("echo err", err_cnt, 0);
`else
    clear_rec();
    send_byte(8'h41);
    wait_resp(0);
    chk("discard ntx", tx_q.size(), 0);
`endif

    busy_fixed = 30;
    clear_rec();
    send_frame({8'h55, 8'h02, 8'h20, 8'h22}, 0);
    for (int k = 0; k < 500 && tx_q.size() < 1; k++) tick();
    repeat (5) tick();
    chk("rst pre ntx", tx_q.size(), 1);
    rst = 1'b1;
    tick();
    chk("rst strobes", {tx_en, reg_we, reg_re, frame_err}, 4'b0000);
    chk("rst tx_data", tx_data, 8'h00);
    chk("rst reg_addr", reg_addr, 8'h00);
    tick();
    rst = 1'b0;
    repeat (80) tick();
    chk("rst post ntx", tx_q.size(), 1);
    if (tx_q.size() > 0) chk("rst post byte", tx_q[0], 8'hAA);
    busy_fixed = -1;
    run_model_frame("after_rst", {8'h55, 8'h01, 8'h33, 8'h77, 8'h01 ^ 8'h33 ^ 8'h77}, 3);

    clear_rec();
    send_byte(8'h55);
    send_byte(8'h01);
    repeat (TO - 1) tick();
    chk("to early", frame_err, 1'b0);
    tick();
    chk("to pulse", frame_err, 1'b1);
    repeat (40) tick();
    chk("to err_cnt", err_cnt, 1);
    chk("to ntx", tx_q.size(), 0);
    chk("to we", we_a_q.size(), 0);

    fr = {8'h55, 8'h01, 8'h44, 8'h99, 8'h01 ^ 8'h44 ^ 8'h99};
    model_frame(fr, etx, kind, a, d, re_cnt, err_cnt);
    clear_rec();
    send_byte(8'h55);
    repeat (TO - 1) tick();
    for (int j = 1; j < 5; j++) send_byte(fr[j]);
    wait_resp(1);
    check_frame("gap_max", {8'hAA}, 1, 8'h44, 8'h99, 0, 0);

    run_model_frame("after_to", {8'h55, 8'h02, 8'h44, 8'h02 ^ 8'h44}, 2);

    busy_max = 12;
    for (int k = 0; k < 60; k++) begin
      kind = $urandom_range(0, 9);
      a = 8'($urandom_range(0, 15));
      d = 8'($urandom);
      if (kind == 0) begin
        c = 8'($urandom_range(3, 255));
        fr = {8'h55, c};
      end else if (kind <= 5) begin
        cs = 8'h01 ^ a ^ d;
        if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
        fr = {8'h55, 8'h01, a, d, cs};
      end else begin
        cs = 8'h02 ^ a;
        if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
        fr = {8'h55, 8'h02, a, cs};
      end
      garb = ($urandom_range(0, 2) == 0);
      g = 8'($urandom);
      if (g == 8'h55) g = 8'h56;
      begin
        logic [7:0] rtx [$];
        int ewe, ere, eerr;
        logic [7:0] ewa, ewd;
        model_frame(fr, rtx, ewe, ewa, ewd, ere, eerr);
`ifdef UART_CMD_ECHO_EN
        if (garb) rtx.push_front(g);
`endif
        clear_rec();
        if (garb) begin
          send_byte(g);
          repeat ($urandom_range(0, 5)) tick();
        end
        send_frame(fr, 8);
        wait_resp(rtx.size());
        check_frame($sformatf("rnd%0d", k), rtx, ewe, ewa, ewd, ere, eerr);
      end
    end

    chk("tx_en while busy", viol_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Byte-level command decoder between the UART receiver and transmitter of the UART loop.
- Consumes received bytes (rx_data/rx_en) and parses fixed-format frames into register-bus writes or reads.
- Drives the transmitter byte interface (tx_data/tx_en, back-pressured by tx_busy) with ack, read-data or error responses.
- Replaces the free-running data generator when the UART is used as a control port.

Parameters:
- HDR_BYTE, 8'h55, frame start byte.
- ACK_BYTE, 8'hAA, positive response byte.
- NAK_BYTE, 8'hEE, error response byte.
- TIMEOUT_CYC, 25920, maximum clk cycles between bytes of one frame (20 bit times at BPS_NUM 1296); counter width $clog2(TIMEOUT_CYC+1).

Ports:
- clk  input  1  system clock, single domain
- rst  input  1  synchronous active-high reset
- rx_data  input  8  received byte, valid when rx_en=1
- rx_en  input  1  one-cycle strobe per received byte
- tx_busy  input  1  transmitter busy; high while a byte shifts out
- tx_data  output  8  byte to transmit, held stable from tx_en until next tx_en
- tx_en  output  1  one-cycle transmit request
- reg_addr  output  8  register address
- reg_wdata  output  8  register write data
- reg_we  output  1  one-cycle write strobe
- reg_re  output  1  one-cycle read strobe
- reg_rdata  input  8  read data, valid exactly 1 cycle after reg_re
- frame_err  output  1  one-cycle pulse on checksum/command/timeout error

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: all outputs 0. State = S_IDLE. Timeout counter = 0. Reset mid-frame or mid-response abandons it; no partial tx_en or reg strobe is issued after reset.
- Frame format: HDR, CMD, ADDR, [DATA], CSUM.
  - CMD 8'h01 = write: includes DATA.
  - CMD 8'h02 = read: no DATA.
  - CSUM = CMD ^ ADDR ^ DATA (write) or CMD ^ ADDR (read).
- States:
  - S_IDLE: rx_en with byte==HDR_BYTE -> S_CMD. Other bytes are silently discarded.
  - S_CMD: rx_en -> latch cmd. 01/02 -> S_ADDR. Else pulse frame_err, queue NAK -> S_RESP.
  - S_ADDR: rx_en -> latch reg_addr. cmd 01 -> S_DATA; cmd 02 -> S_CSUM.
  - S_DATA: rx_en -> latch reg_wdata -> S_CSUM.
  - S_CSUM: rx_en. Mismatch -> frame_err pulse, queue NAK -> S_RESP. Match -> S_EXEC.
  - S_EXEC (1 cycle):
    - Write: reg_we=1, queue ACK -> S_RESP.
    - Read: reg_re=1 -> S_RDLAT.
  - S_RDLAT (1 cycle): capture reg_rdata, queue ACK then data -> S_RESP.
  - S_RESP: send each queued byte using the tx handshake below. After the last byte -> S_IDLE.
- Timeout: in S_CMD..S_CSUM the counter resets on each rx_en and increments otherwise. On reaching TIMEOUT_CYC: frame_err pulse, return to S_IDLE, no response sent.
- tx handshake:
  - tx_en is pulsed only when tx_busy==0 and the guard counter has expired.
  - After each tx_en, tx_busy is ignored for 2 cycles (covers transmitter latch latency).
  - Then wait for tx_busy==0 before the next byte.
- rx_en arriving in S_EXEC, S_RDLAT or S_RESP is dropped; it does not restart parsing.
- Latency:
  - reg_we asserts 1 cycle after the CSUM rx_en.
  - reg_re asserts 1 cycle after the CSUM rx_en.
  - First tx_en follows at the earliest 1 cycle after leaving S_EXEC/S_RDLAT, gated by tx_busy.
- reg_addr and reg_wdata hold their last values until overwritten by the next frame.

Optional Feature:
- Macro: UART_CMD_ECHO_EN.
- Defined: in S_IDLE, every received byte other than HDR_BYTE is echoed back via the tx handshake. Bytes arriving while an echo is pending are dropped. An echo in progress completes before HDR parsing continues; the HDR itself is still accepted.
- Undefined: no echo logic is built; non-header bytes are discarded and tx_en only ever carries frame responses.

Test Plan:
- Write frame 55 01 10 3C 2D -> one reg_we pulse with reg_addr=10, reg_wdata=3C; tx byte AA; frame_err never asserts.
- Read frame 55 02 20 22 with reg_rdata=5A -> reg_re pulse with reg_addr=20; tx bytes AA then 5A in order; second tx_en only after tx_busy falls.
- Bad checksum 55 01 10 3C 00 -> frame_err pulse, no reg_we, tx byte EE.
- Bad command 55 07 -> frame_err, tx EE, back to S_IDLE; the following valid write frame is executed normally.
- Timeout: send 55 01, then idle TIMEOUT_CYC cycles -> frame_err pulse, no tx_en; a next full frame still works.
- Reset: rst asserted during the AA/5A response -> outputs 0 next cycle, no further tx_en; with UART_CMD_ECHO_EN, byte 41 in idle -> tx 41.
